// File: rtl/maxpool2d_stream.sv
// Streaming 2x2/stride-2 signed max-pool with a half-row line buffer and valid/ready handshake.
// Define MAXPOOL_RELU_EN to clamp negative pooled lanes to zero (fused ReLU).
module maxpool2d_stream #(
    parameter int unsigned dataColNum = 28,
    parameter int unsigned dataRowNum = 28,
    parameter int unsigned wordlength = 16,
    parameter int unsigned channels   = 1
) (
    input  logic                           clk,
    input  logic                           irst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [channels*wordlength-1:0] pixels,
    output logic [channels*wordlength-1:0] data_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last
);

    localparam int unsigned DW = channels * wordlength;
    localparam int unsigned PC = dataColNum / 2;
    localparam int unsigned PR = dataRowNum / 2;
    localparam int unsigned CW = $clog2(dataColNum);
    localparam int unsigned RW = $clog2(dataRowNum);
    localparam int unsigned IW = (PC > 1) ? $clog2(PC) : 1;
    localparam logic [CW-1:0] ColLast = CW'(dataColNum - 1);
    localparam logic [RW-1:0] RowLast = RW'(dataRowNum - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [DW-1:0] h_q;
    logic [DW-1:0] data_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [DW-1:0] lb [PC];

    logic          accept;
    logic          col_wrap;
    logic          row_wrap;
    logic          in_win;
    logic          last_win;
    logic [IW-1:0] lb_idx;
    logic [DW-1:0] lb_rd;
    logic [DW-1:0] max_hp;
    logic [DW-1:0] max_lp;
    logic [DW-1:0] pooled;

    function automatic logic [wordlength-1:0] smax(input logic [wordlength-1:0] a,
                                                   input logic [wordlength-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign in_ready  = !irst && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign col_wrap  = (col_q == ColLast);
    assign row_wrap  = (row_q == RowLast);
    // Odd trailing column/row fall outside every window and are consumed silently.
    assign in_win    = (32'(col_q) < 2 * PC) && (32'(row_q) < 2 * PR);
    assign last_win  = (32'(row_q) == 2 * PR - 1) && (32'(col_q) == 2 * PC - 1);
    assign lb_idx    = IW'(col_q >> 1);
    assign lb_rd     = lb[lb_idx];

    always_comb begin
        max_hp = '0;
        max_lp = '0;
        pooled = '0;
        for (int k = 0; k < int'(channels); k++) begin
            max_hp[k*wordlength +: wordlength] =
                smax(h_q[k*wordlength +: wordlength], pixels[k*wordlength +: wordlength]);
            max_lp[k*wordlength +: wordlength] =
                smax(lb_rd[k*wordlength +: wordlength], pixels[k*wordlength +: wordlength]);
`ifdef MAXPOOL_RELU_EN
            pooled[k*wordlength +: wordlength] = max_hp[k*wordlength + wordlength - 1] ?
                '0 : max_hp[k*wordlength +: wordlength];
`else
            pooled[k*wordlength +: wordlength] = max_hp[k*wordlength +: wordlength];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (accept) begin
                col_q <= col_wrap ? '0 : col_q + CW'(1);
                if (col_wrap) begin
                    row_q <= row_wrap ? '0 : row_q + RW'(1);
                end
                if (in_win) begin
                    case ({row_q[0], col_q[0]})
                        2'b00:   h_q <= pixels;
                        2'b10:   h_q <= max_lp;
                        2'b11: begin
                            // Overrides the consume-clear above when a new window completes.
                            data_q      <= pooled;
                            out_valid_q <= 1'b1;
                            out_last_q  <= last_win;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Top row of each window pair leaves its horizontal max here for the row below.
    always_ff @(posedge clk) begin
        if (accept && in_win && !row_q[0] && col_q[0]) begin
            lb[lb_idx] <= max_hp;
        end
    end

    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Directed self-checking bench: 4x4 three-lane instance and 5x5 single-lane instance.
module tb_maxpool2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        irst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [47:0] a_pixels, a_data_out;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [15:0] b_pixels, b_data_out;

    int checks = 0;
    int errors = 0;

    maxpool2d_stream #(
        .dataColNum(4), .dataRowNum(4), .wordlength(16), .channels(3)
    ) u_dut_a (
        .clk(clk), .irst(irst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .pixels(a_pixels), .data_out(a_data_out), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last)
    );

    maxpool2d_stream #(
        .dataColNum(5), .dataRowNum(5), .wordlength(16), .channels(1)
    ) u_dut_b (
        .clk(clk), .irst(irst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pixels(b_pixels), .data_out(b_data_out), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last)
    );

    // -1 marks beats that must not produce an output.
    int exp_a [16] = '{-1, -1, -1, -1, -1, 5, -1, 7, -1, -1, -1, -1, -1, 13, -1, 15};
    int exp_b [25] = '{-1, -1, -1, -1, -1, -1, 6, -1, 8, -1, -1, -1, -1, -1, -1, -1,
                       16, -1, 18, -1, -1, -1, -1, -1, -1};

    logic [15:0] neg_px [16] = '{16'h8000, 16'hFFFB, 16'h8000, 16'h8000,
                                 16'hFFF9, 16'hFF9C, 16'h8000, 16'h8000,
                                 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC,
                                 16'hFFF7, 16'hFFF8, 16'hFFF9, 16'hFFFA};
`ifdef MAXPOOL_RELU_EN
    logic [15:0] neg_exp [16] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                  16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
`else
    logic [15:0] neg_exp [16] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFB, 16'h0, 16'h8000,
                                  16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFD};
`endif

    function automatic logic [47:0] pack3(input int v);
        return {16'(v + 200), 16'(v + 100), 16'(v)};
    endfunction

    function automatic logic [47:0] rep3(input logic [15:0] v);
        return {v, v, v};
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat_a(input logic [47:0] px, input logic ev, input logic [47:0] ed,
                          input logic el);
        a_pixels   = px;
        a_in_valid = 1'b1;
        #1;
        chk("a_in_ready", 48'(a_in_ready), 48'd1);
        @(posedge clk);
        #1;
        chk("a_out_valid", 48'(a_out_valid), 48'(ev));
        chk("a_out_last", 48'(a_out_last), 48'(el));
        if (ev) chk("a_data_out", a_data_out, ed);
    endtask

    task automatic beat_b(input int px, input int ex, input logic el);
        b_pixels   = 16'(px);
        b_in_valid = 1'b1;
        #1;
        chk("b_in_ready", 48'(b_in_ready), 48'd1);
        @(posedge clk);
        #1;
        chk("b_out_valid", 48'(b_out_valid), 48'(ex >= 0));
        chk("b_out_last", 48'(b_out_last), 48'(el));
        if (ex >= 0) chk("b_data_out", 48'(b_data_out), 48'(ex));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        irst        = 1'b1;
        a_in_valid  = 1'b0;
        a_pixels    = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_pixels    = '0;
        b_out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 48'(a_out_valid), 48'd0);
        chk("rst_out_last", 48'(a_out_last), 48'd0);
        chk("rst_data_out", a_data_out, 48'd0);
        chk("rst_in_ready", 48'(a_in_ready), 48'd0);
        irst = 1'b0;

        // Ramp frame, three lanes offset by 100*k
        for (int i = 0; i < 16; i++) beat_a(pack3(i), exp_a[i] >= 0, pack3(exp_a[i]), i == 15);

        // All-negative frame, including a window of all -32768
        for (int i = 0; i < 16; i++)
            beat_a(rep3(neg_px[i]), exp_a[i] >= 0, rep3(neg_exp[i]), i == 15);

        // Back-pressure: hold pooled 5 for 10 cycles while beat 6 waits
        for (int i = 0; i < 6; i++) beat_a(pack3(i), exp_a[i] >= 0, pack3(exp_a[i]), 1'b0);
        a_out_ready = 1'b0;
        a_pixels    = pack3(6);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_in_ready", 48'(a_in_ready), 48'd0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 48'(a_out_valid), 48'd1);
            chk("bp_data_out", a_data_out, pack3(5));
        end
        a_out_ready = 1'b1;
        for (int i = 6; i < 16; i++) beat_a(pack3(i), exp_a[i] >= 0, pack3(exp_a[i]), i == 15);
        a_in_valid = 1'b0;

        // Odd geometry 5x5, two back-to-back frames
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 25; i++) beat_b(i, exp_b[i], i == 18);
        b_in_valid = 1'b0;

        // Reset mid-frame with an output pending
        for (int i = 0; i < 6; i++) beat_a(pack3(i), exp_a[i] >= 0, pack3(exp_a[i]), 1'b0);
        irst     = 1'b1;
        a_pixels = pack3(6);
        #1;
        chk("mid_rst_in_ready", 48'(a_in_ready), 48'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 48'(a_out_valid), 48'd0);
        chk("mid_rst_in_ready2", 48'(a_in_ready), 48'd0);
        irst = 1'b0;
        for (int i = 0; i < 16; i++) beat_a(pack3(i), exp_a[i] >= 0, pack3(exp_a[i]), i == 15);
        a_in_valid = 1'b0;

        @(posedge clk);
        #1;
        chk("idle_out_valid", 48'(a_out_valid), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
